// File: rtl/tag_ram_ctrl_if.sv
// rtl/tag_ram_ctrl_if.sv - request, response and RAM-side bundle for tag_ram_ctrl
//
// Purpose: groups every tag_ram_ctrl signal except clk/rst.
//   slave  : the controller side (tag_ram_ctrl).
//   master : the requester and RAM-model side.
// Signals:
//   init_req / init_busy               : init sweep request and busy flag
//   a_req/a_addr/a_gnt                 : reader A
//   b_req/b_addr/b_gnt                 : reader B
//   w_req/w_addr/w_data/w_gnt          : writer
//   rsp_valid/rsp_id/rsp_data          : read response (id 0=A, 1=B)
//   ram_re/ram_raddr/ram_rd            : RAM read port (1-cycle registered read)
//   ram_we/ram_waddr/ram_wr            : RAM write port
interface tag_ram_ctrl_if;
  logic        init_req;
  logic        init_busy;
  logic        a_req;
  logic [6:0]  a_addr;
  logic        a_gnt;
  logic        b_req;
  logic [6:0]  b_addr;
  logic        b_gnt;
  logic        w_req;
  logic [6:0]  w_addr;
  logic [23:0] w_data;
  logic        w_gnt;
  logic        rsp_valid;
  logic        rsp_id;
  logic [23:0] rsp_data;
  logic        ram_re;
  logic [6:0]  ram_raddr;
  logic [23:0] ram_rd;
  logic        ram_we;
  logic [6:0]  ram_waddr;
  logic [23:0] ram_wr;

  modport slave (
    input  init_req, a_req, a_addr, b_req, b_addr, w_req, w_addr, w_data, ram_rd,
    output init_busy, a_gnt, b_gnt, w_gnt, rsp_valid, rsp_id, rsp_data,
    output ram_re, ram_raddr, ram_we, ram_waddr, ram_wr
  );

  modport master (
    output init_req, a_req, a_addr, b_req, b_addr, w_req, w_addr, w_data, ram_rd,
    input  init_busy, a_gnt, b_gnt, w_gnt, rsp_valid, rsp_id, rsp_data,
    input  ram_re, ram_raddr, ram_we, ram_waddr, ram_wr
  );
endinterface

// File: rtl/tag_ram_ctrl.sv
// rtl/tag_ram_ctrl.sv - 128x24 tag RAM controller: init sweep, two-reader arbitration, one writer
//
// Purpose: fronts a 128x24 1R1W RAM with a 1-cycle registered read.
//   INIT : writes INIT_VALUE to addresses 0..127, one per cycle, all requests ignored.
//   IDLE : writer always granted; at most one reader per cycle, round-robin on contention.
//          Read response appears one cycle after the grant.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : tag_ram_ctrl_if.slave (requesters, response, RAM ports)
module tag_ram_ctrl #(
  parameter logic [23:0] INIT_VALUE = 24'h000000
) (
  input  logic           clk,
  input  logic           rst,
  tag_ram_ctrl_if.slave  bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_cnt;
  logic [6:0]  w_cnt_nxt;
  logic        r_rr_b;        // 1: B wins the next contended cycle
  logic        w_rr_nxt;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic        r_fwd;
  logic [23:0] r_fwd_data;

  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_gnt_w;
  logic        w_rd_gnt;
  logic [6:0]  w_raddr;
  logic        w_fwd;

  assign w_rd_gnt = w_gnt_a | w_gnt_b;
  assign w_raddr  = w_gnt_b ? bus.b_addr : bus.a_addr;
  // The RAM returns old data on a same-address read/write, so the write data is captured instead.
  assign w_fwd    = w_rd_gnt & w_gnt_w & (bus.w_addr == w_raddr);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rr_nxt      = r_rr_b;
    w_gnt_a       = 1'b0;
    w_gnt_b       = 1'b0;
    w_gnt_w       = 1'b0;
    bus.ram_re    = 1'b0;
    bus.ram_raddr = 7'd0;
    bus.ram_we    = 1'b0;
    bus.ram_waddr = 7'd0;
    bus.ram_wr    = 24'd0;
    // Reset keeps every strobe low combinationally, not just from the next edge.
    if (rst) begin
      case (r_state)
        ST_INIT: begin
          bus.ram_we    = 1'b1;
          bus.ram_waddr = r_cnt;
          bus.ram_wr    = INIT_VALUE;
          w_cnt_nxt     = r_cnt + 7'd1;   // wraps back to 0 after 127
          if (r_cnt == 7'd127) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_IDLE: begin
          w_gnt_w = bus.w_req;
          if (bus.a_req && (!bus.b_req || !r_rr_b)) begin
            w_gnt_a = 1'b1;
          end else if (bus.b_req) begin
            w_gnt_b = 1'b1;
          end
          if (w_gnt_a) begin
            w_rr_nxt = 1'b1;
          end else if (w_gnt_b) begin
            w_rr_nxt = 1'b0;
          end
          bus.ram_re    = w_rd_gnt;
          bus.ram_raddr = w_rd_gnt ? w_raddr : 7'd0;
          if (w_gnt_w) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = bus.w_addr;
            bus.ram_wr    = bus.w_data;
          end
          if (bus.init_req) begin
            w_state_nxt = ST_INIT;
          end
        end
        default: begin
          w_state_nxt = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= 7'd0;
      r_rr_b      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_fwd       <= 1'b0;
      r_fwd_data  <= 24'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rr_b      <= w_rr_nxt;
      r_rsp_valid <= w_rd_gnt;
      r_rsp_id    <= w_gnt_b;
      r_fwd       <= w_fwd;
      r_fwd_data  <= bus.w_data;
    end
  end

  assign bus.init_busy = !rst || (r_state == ST_INIT);
  assign bus.a_gnt     = w_gnt_a;
  assign bus.b_gnt     = w_gnt_b;
  assign bus.w_gnt     = w_gnt_w;
  assign bus.rsp_valid = r_rsp_valid & rst;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_fwd ? r_fwd_data : bus.ram_rd;

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// tb/tb_tag_ram_ctrl.sv - scoreboard bench for tag_ram_ctrl with a behavioural 128x24 RAM
module tb_tag_ram_ctrl;
  localparam logic [23:0] INIT_V = 24'h000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tag_ram_ctrl_if bus ();

  tag_ram_ctrl #(.INIT_VALUE(INIT_V)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // RAM model: registered read returning pre-write contents on a same-address collision
  logic [23:0] mem [128];
  logic [23:0] rd_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wr;
    if (bus.ram_re) rd_q <= mem[bus.ram_raddr];
  end
  assign bus.ram_rd = rd_q;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          due;
    logic        id;
    logic [23:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc_n);
    end
  endtask

  // Monitor: pops one expectation per presented response
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_cycle", cyc_n, mon_e.due);
        chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, mon_e.id});
        chk("rsp_data", {8'd0, bus.rsp_data}, {8'd0, mon_e.data});
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc_n) begin
      chk("rsp_missing", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  end

  task automatic drive(input logic a, input logic [6:0] aa, input logic b, input logic [6:0] ba,
                       input logic w, input logic [6:0] wa, input logic [23:0] wd);
    bus.a_req  = a;  bus.a_addr = aa;
    bus.b_req  = b;  bus.b_addr = ba;
    bus.w_req  = w;  bus.w_addr = wa;  bus.w_data = wd;
  endtask

  // One IDLE cycle: drive, check grants at negedge, queue the expected response
  task automatic cyc(input logic a, input logic [6:0] aa, input logic b, input logic [6:0] ba,
                     input logic w, input logic [6:0] wa, input logic [23:0] wd,
                     input logic eg_a, input logic eg_b, input logic [23:0] ed);
    exp_t e;
    drive(a, aa, b, ba, w, wa, wd);
    @(negedge clk);
    chk("a_gnt", {31'd0, bus.a_gnt}, {31'd0, eg_a});
    chk("b_gnt", {31'd0, bus.b_gnt}, {31'd0, eg_b});
    chk("w_gnt", {31'd0, bus.w_gnt}, {31'd0, w});
    e.due = cyc_n + 1;
    e.data = ed;
    if (eg_a) begin e.id = 1'b0; exp_q.push_back(e); end
    if (eg_b) begin e.id = 1'b1; exp_q.push_back(e); end
    @(posedge clk); #1;
  endtask

  // Checks n consecutive sweep writes starting at address 0; init_req pulsed early is ignored
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      bus.init_req = (i < 3);
      @(negedge clk);
      chk("sweep_write", {bus.ram_we, bus.ram_waddr, bus.ram_wr}, {1'b1, 7'(i), INIT_V});
      chk("sweep_quiet", {27'd0, bus.a_gnt, bus.b_gnt, bus.w_gnt, bus.ram_re, bus.init_busy},
          32'd1);
      @(posedge clk); #1;
    end
    bus.init_req = 1'b0;
  endtask

  task automatic reset_quiet(input string nm);
    @(negedge clk);
    chk(nm, {25'd0, bus.a_gnt, bus.b_gnt, bus.w_gnt, bus.ram_re, bus.ram_we, bus.rsp_valid,
             bus.init_busy}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 24'h5A0000 | 24'(i);
    rd_q = 24'd0;
    bus.init_req = 1'b0;
    drive(1'b1, 7'd1, 1'b0, 7'd0, 1'b1, 7'd2, 24'h999999);
    @(posedge clk); #1;
    reset_quiet("reset_state");
    reset_quiet("reset_state_hold");
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Power-up sweep
    sweep(128);
    @(negedge clk);
    chk("init_busy_low", {31'd0, bus.init_busy}, 32'd0);
    @(posedge clk); #1;

    cyc(1, 3,   0, 0,   0, 0, 24'h0,      1, 0, 24'h000000);
    cyc(0, 0,   1, 127, 0, 0, 24'h0,      0, 1, 24'h000000);
    cyc(0, 0,   0, 0,   1, 5, 24'hABCDEF, 0, 0, 24'h0);
    cyc(1, 5,   0, 0,   0, 0, 24'h0,      1, 0, 24'hABCDEF);
    cyc(0, 0,   1, 7,   0, 0, 24'h0,      0, 1, 24'h000000);
    // Contention with pointer favouring A
    cyc(1, 5,   1, 127, 0, 0, 24'h0,      1, 0, 24'hABCDEF);
    cyc(1, 5,   1, 127, 0, 0, 24'h0,      0, 1, 24'h000000);
    cyc(1, 5,   1, 127, 0, 0, 24'h0,      1, 0, 24'hABCDEF);
    cyc(1, 5,   1, 127, 0, 0, 24'h0,      0, 1, 24'h000000);
    // Same-cycle write/read forwarding, then normal read-back
    cyc(0, 0,   1, 9,   1, 9, 24'h123456, 0, 1, 24'h123456);
    cyc(1, 9,   0, 0,   0, 0, 24'h0,      1, 0, 24'h123456);
    // Back-to-back reads with concurrent writes
    cyc(1, 5,   0, 0,   1, 20, 24'h111111, 1, 0, 24'hABCDEF);
    cyc(0, 0,   1, 20,  1, 21, 24'h222222, 0, 1, 24'h111111);
    cyc(1, 21,  1, 20,  0, 0,  24'h0,      1, 0, 24'h222222);
    cyc(1, 21,  1, 20,  0, 0,  24'h0,      0, 1, 24'h111111);

    // init_req mid-traffic: the read granted in the last IDLE cycle still responds
    bus.init_req = 1'b1;
    cyc(1, 5,   0, 0,   1, 30, 24'h777777, 1, 0, 24'hABCDEF);
    drive(1, 5, 1, 9, 1, 40, 24'h444444);
    sweep(128);
    cyc(1, 5,   0, 0,   0, 0, 24'h0,      1, 0, INIT_V);
    cyc(0, 0,   1, 9,   0, 0, 24'h0,      0, 1, INIT_V);
    cyc(1, 30,  0, 0,   0, 0, 24'h0,      1, 0, INIT_V);
    cyc(0, 0,   1, 21,  0, 0, 24'h0,      0, 1, INIT_V);

    // Reset at sweep address 60 restarts the sweep from 0 and covers the full range
    cyc(0, 0,   0, 0,   1, 100, 24'hABABAB, 0, 0, 24'h0);
    bus.init_req = 1'b1;
    cyc(0, 0,   0, 0,   0, 0, 24'h0,      0, 0, 24'h0);
    sweep(60);
    rst = 1'b0;
    reset_quiet("mid_sweep_reset");
    reset_quiet("mid_sweep_reset_hold");
    rst = 1'b1;
    sweep(128);
    cyc(0, 0,   1, 100, 0, 0, 24'h0,      0, 1, INIT_V);

    // A response pending at reset is discarded
    drive(1, 20, 0, 0, 0, 0, 24'h0);
    @(negedge clk);
    chk("discard_gnt", {31'd0, bus.a_gnt}, 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 24'h0);
    rst = 1'b0;
    reset_quiet("discard_rsp");
    rst = 1'b1;
    sweep(128);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
